sap_cpu: RTL and testbench
==========================

Name: sap_cpu

Overview:
- Parametrised successor to the 8-bit SAP core: an accumulator CPU with generic data and address widths.
- Contains internal program/data RAM, loaded through a write port while the core is stopped.
- Adds STA, LDI, JMP, JC and JZ, carry/zero flags, a HALT state with run restart, and a valid-qualified output register.
- Multi-cycle controller: fixed fetch, then variable-length execute.

Parameters:
- DATA_W, 8, width of the accumulator, B register, RAM words, ALU and output; must satisfy DATA_W >= 4 + ADDR_W.
- ADDR_W, 4, width of the PC, MAR and instruction operand; RAM depth is 2**ADDR_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- run  in  1  one-cycle pulse; starts execution from IDLE or HALT.
- prog_we  in  1  RAM write strobe; honoured only in IDLE or HALT.
- prog_addr  in  ADDR_W  RAM write address.
- prog_data  in  DATA_W  RAM write data.
- out_data  out  DATA_W  output register.
- out_valid  out  1  one-cycle pulse when out_data is updated.
- halted  out  1  high in IDLE and HALT.
- pc_dbg  out  ADDR_W  current PC.

Behaviour:
- Reset:
  - State = IDLE; PC, MAR, IR, A, B, flags C/Z and out_data are all 0.
  - out_valid = 0, halted = 1.
  - RAM contents are not cleared.
- Instruction format: opcode = word[DATA_W-1 -: 4]; operand = word[ADDR_W-1:0]; the remaining middle bits are ignored.
- Opcodes:
  - 0 LDA, 1 ADD, 2 SUB, 4 STA, 5 LDI, 6 JMP, 7 JC, 8 JZ, E OUT, F HLT.
  - All others (3, 9-D) are NOPs.
- RAM read is combinational: mem[MAR].
- State sequence, one clock per state:
  - T1: MAR <= PC.
  - T2: IR <= mem[MAR]; PC <= PC+1, wrapping from 2**ADDR_W-1 to 0.
  - T3 by opcode:
    - LDA/ADD/SUB/STA: MAR <= operand.
    - LDI: A <= zero-extended operand; next state T1.
    - JMP: PC <= operand; next state T1.
    - JC: PC <= operand if C=1; next state T1.
    - JZ: PC <= operand if Z=1; next state T1.
    - OUT: out_data <= A; out_valid = 1 for this cycle only; next state T1.
    - HLT: next state HALT.
    - NOP: next state T1.
  - T4:
    - LDA: A <= mem[MAR]; next state T1.
    - STA: mem[MAR] <= A; next state T1.
    - ADD/SUB: B <= mem[MAR].
  - T5 (ADD/SUB only): A <= A+B or A-B, truncated to DATA_W bits.
    - C = carry-out for ADD; C = not-borrow (A >= B, unsigned) for SUB.
    - Z = (result == 0).
    - Next state T1.
- Flags change only in T5; LDA, LDI and the rest leave C/Z unchanged.
- Instruction cycle counts: LDI/JMP/JC/JZ/OUT/NOP = 3, LDA/STA = 4, ADD/SUB = 5, HLT = 3 then stop.
- IDLE/HALT:
  - halted = 1.
  - A and out_data hold their values.
  - run => PC <= 0, C <= 0, Z <= 0, next state T1; A is preserved.
- run outside IDLE/HALT is ignored.
- prog_we:
  - In IDLE/HALT: mem[prog_addr] <= prog_data.
  - In the same cycle as run: the write is performed, and the first fetch (2 cycles later) sees it.
  - While running: ignored, and RAM is unchanged.
- reset mid-instruction: takes effect on the next edge; an in-flight STA does not write if reset is high in T4.
- out_valid is never asserted outside T3 of OUT.

Decomposition:
- Package sap_pkg:
  - opcode enum (4 bits).
  - controller state enum (IDLE, T1..T5, HALT).
  - ALU result struct {sum, carry}.
- One natural sub-module: sap_alu.
  - Combinational, parametrised DATA_W.
  - Inputs a, b, sub; outputs result, carry, zero.
- Controller FSM and datapath registers stay in sap_cpu.

Test Plan:
- Load {0:LDA 9, 1:ADD A, 2:OUT, 3:HLT, 9:0x1C, A:0x0E}, then pulse run.
  - out_valid once, with out_data=0x2A; C=0, Z=0.
  - halted rises 15 cycles after run.
- Overflow/zero: A=0xFF plus mem 0x01 via ADD.
  - Result 0x00, C=1, Z=1.
  - A following JZ 7 lands at PC=7; JC is also taken.
- SUB borrow: 0x05-0x07 gives A=0xFE, C=0, Z=0; a JC to 4 is not taken and PC advances by 1.
- STA/LDI: LDI 6; STA C; LDA C; OUT gives out_data=0x06, and mem[C]=0x06 is read back via a second program.
- PC wrap: JMP F with mem[F]=OUT then mem[0]=HLT gives OUT executed, then a fetch at PC=0, then halt; pc_dbg shows F->0.
- Control/boundary checks:
  - prog_we during execution leaves RAM unchanged.
  - reset asserted in T4 of STA gives no write, all outputs 0 and halted=1 next cycle.
  - Two consecutive run pulses from HALT restart at PC=0 each time.

Source files
------------

// File: rtl/sap_pkg.sv
`default_nettype none
// sap_pkg: shared opcode, controller-state and ALU-result types for sap_cpu | rev 1.0
package sap_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_HALT = 3'd6
  } state_e;

  // Upper bound on DATA_W; narrower ALUs leave the high sum bits at zero.
  localparam int SAP_MAX_W = 32;

  typedef struct packed {
    logic                 carry;
    logic [SAP_MAX_W-1:0] sum;
  } alu_res_t;

endpackage
`default_nettype wire

// File: rtl/sap_alu.sv
`default_nettype none
// sap_alu: combinational add/subtract with carry (not-borrow on subtract) and zero | rev 1.0
module sap_alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sub_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              zero_o
);
  import sap_pkg::*;

  logic [DATA_W:0] w_full;
  alu_res_t        w_res;

  // Subtract as a + ~b + 1 so the carry-out is directly the not-borrow flag.
  always_comb begin
    w_full = {1'b0, a_i} + {1'b0, (sub_i ? ~b_i : b_i)} + {{DATA_W{1'b0}}, sub_i};
    w_res = '0;
    w_res.sum[DATA_W-1:0] = w_full[DATA_W-1:0];
    w_res.carry = w_full[DATA_W];
  end

  assign result_o = w_res.sum[DATA_W-1:0];
  assign carry_o  = w_res.carry;
  assign zero_o   = (w_res.sum == '0);

endmodule
`default_nettype wire

// File: rtl/sap_cpu.sv
`default_nettype none
// sap_cpu: multi-cycle accumulator CPU with internal RAM, loaded while stopped | rev 1.0
module sap_cpu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_dbg
);
  import sap_pkg::*;

  localparam logic [ADDR_W-1:0] PC_INC = 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, mar_q, mar_d;
  logic [ADDR_W+3:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, out_q, out_d;
  logic                c_q, c_d, z_q, z_d;
  logic [DATA_W-1:0]   mem_q [2**ADDR_W];

  logic [DATA_W-1:0]   w_rd;
  opcode_e             w_op;
  logic [ADDR_W-1:0]   w_operand;
  logic                w_stopped;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic [DATA_W-1:0]   w_alu_result;
  logic                w_alu_carry, w_alu_zero;

  assign w_rd      = mem_q[mar_q];
  assign w_op      = opcode_e'(ir_q[ADDR_W+3 -: 4]);
  assign w_operand = ir_q[ADDR_W-1:0];
  assign w_stopped = (state_q == S_IDLE) || (state_q == S_HALT);

  sap_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .sub_i    (w_op == OP_SUB),
    .result_o (w_alu_result),
    .carry_o  (w_alu_carry),
    .zero_o   (w_alu_zero)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mar_d       = mar_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    z_d         = z_q;
    out_d       = out_q;
    out_valid   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = prog_addr;
    w_mem_wdata = prog_data;
    case (state_q)
      S_IDLE, S_HALT: begin
        w_mem_we = prog_we;
        if (run) begin
          pc_d    = '0;
          c_d     = 1'b0;
          z_d     = 1'b0;
          state_d = S_T1;
        end
      end
      S_T1: begin
        mar_d   = pc_q;
        state_d = S_T2;
      end
      S_T2: begin
        // Only the opcode and operand fields are kept; middle bits are don't-care.
        ir_d    = {w_rd[DATA_W-1 -: 4], w_rd[ADDR_W-1:0]};
        pc_d    = pc_q + PC_INC;
        state_d = S_T3;
      end
      S_T3: begin
        state_d = S_T1;
        case (w_op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            mar_d   = w_operand;
            state_d = S_T4;
          end
          OP_LDI: a_d = {{(DATA_W-ADDR_W){1'b0}}, w_operand};
          OP_JMP: pc_d = w_operand;
          OP_JC:  if (c_q) pc_d = w_operand;
          OP_JZ:  if (z_q) pc_d = w_operand;
          OP_OUT: begin
            out_d     = a_q;
            out_valid = 1'b1;
          end
          OP_HLT: state_d = S_HALT;
          default: ;
        endcase
      end
      S_T4: begin
        state_d = S_T1;
        case (w_op)
          OP_LDA: a_d = w_rd;
          OP_STA: begin
            w_mem_we    = 1'b1;
            w_mem_addr  = mar_q;
            w_mem_wdata = a_q;
          end
          OP_ADD, OP_SUB: begin
            b_d     = w_rd;
            state_d = S_T5;
          end
          default: ;
        endcase
      end
      S_T5: begin
        a_d     = w_alu_result;
        c_d     = w_alu_carry;
        z_d     = w_alu_zero;
        state_d = S_T1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      mar_q   <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      z_q     <= z_d;
      out_q   <= out_d;
    end
  end

  // RAM survives reset; a write pending in the reset cycle is dropped.
  always_ff @(posedge clock) begin
    if (w_mem_we && !reset) mem_q[w_mem_addr] <= w_mem_wdata;
  end

  assign out_data = out_q;
  assign halted   = w_stopped;
  assign pc_dbg   = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_sap_cpu.sv
`default_nettype none
// tb_sap_cpu: directed programs checked against an instruction-level model of the CPU | rev 1.0
module tb_sap_cpu;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = 4'h0;
  logic [7:0] prog_data = 8'h00;
  logic [7:0] out_data;
  logic       out_valid;
  logic       halted;
  logic [3:0] pc_dbg;

  always #5 clock = ~clock;

  sap_cpu #(.DATA_W(8), .ADDR_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .halted    (halted),
    .pc_dbg    (pc_dbg)
  );

  typedef struct {
    bit       h;
    bit       ov;
    bit [3:0] pc;
    bit [7:0] od;
  } exp_t;

  exp_t     q[$];
  exp_t     cur;
  int       checks = 0;
  int       errors = 0;
  bit [7:0] m[16];
  bit [7:0] img[16];
  bit [7:0] ma = 8'h00;
  bit [7:0] mout = 8'h00;
  bit       mc = 1'b0;
  bit       mz = 1'b0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle expectations: every cycle of a running program, then the first halted cycle.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      check8("halted", 8'(halted), 8'(cur.h));
      check8("out_valid", 8'(out_valid), 8'(cur.ov));
      check8("pc_dbg", 8'(pc_dbg), 8'(cur.pc));
      check8("out_data", out_data, cur.od);
    end else if (!reset) begin
      check8("out_valid_idle", 8'(out_valid), 8'h00);
    end
  end

  task automatic push(input bit h, input bit ov, input bit [3:0] pc);
    exp_t e;
    e.h = h; e.ov = ov; e.pc = pc; e.od = mout;
    q.push_back(e);
  endtask

  // Instruction-set model: executes from PC 0 until HLT, emitting one entry per clock.
  task automatic build_trace();
    bit [3:0] p, np, opd;
    bit [7:0] w, b;
    bit [8:0] s;
    p = 4'h0; mc = 1'b0; mz = 1'b0;
    for (int n = 0; n < 64; n++) begin
      w = m[p]; opd = w[3:0]; np = p + 4'd1;
      push(0, 0, p); push(0, 0, p);
      case (w[7:4])
        4'h0: begin push(0, 0, np); push(0, 0, np); ma = m[opd]; end
        4'h1, 4'h2: begin
          push(0, 0, np); push(0, 0, np); push(0, 0, np);
          b = m[opd];
          if (w[7:4] == 4'h1) begin
            s = {1'b0, ma} + {1'b0, b}; mc = s[8]; ma = s[7:0];
          end else begin
            mc = (ma >= b); ma = ma - b;
          end
          mz = (ma == 8'h00);
        end
        4'h4: begin push(0, 0, np); push(0, 0, np); m[opd] = ma; end
        4'h5: begin push(0, 0, np); ma = {4'h0, opd}; end
        4'h6: begin push(0, 0, np); np = opd; end
        4'h7: begin push(0, 0, np); if (mc) np = opd; end
        4'h8: begin push(0, 0, np); if (mz) np = opd; end
        4'hE: begin push(0, 1, np); mout = ma; end
        4'hF: begin push(0, 0, np); push(1, 0, np); return; end
        default: push(0, 0, np);
      endcase
      p = np;
    end
  endtask

  task automatic load(input bit [3:0] a, input bit [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d; m[a] = d;
    @(posedge clock); #1;
    prog_we = 1'b0;
  endtask

  task automatic load_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) load(4'(i), img[i]);
  endtask

  task automatic clr_img();
    foreach (img[i]) img[i] = 8'h00;
  endtask

  task automatic go(input bit with_we, input bit [3:0] a, input bit [7:0] d, input bit use_model);
    run = 1'b1;
    if (with_we) begin
      prog_we = 1'b1; prog_addr = a; prog_data = d; m[a] = d;
    end
    @(posedge clock); #1;
    run = 1'b0; prog_we = 1'b0;
    if (use_model) build_trace();
  endtask

  // Drains the expectation queue; optionally pokes RAM or pulses run while the core is busy.
  task automatic finish_run(input int poke_cycles, input int rerun_at);
    int n;
    n = 0;
    while (q.size() > 0 && n < 400) begin
      if (n < poke_cycles) begin
        prog_we = 1'b1; prog_addr = 4'h9; prog_data = 8'h33;
      end else prog_we = 1'b0;
      run = (n == rerun_at);
      @(posedge clock); #1;
      n++;
    end
    prog_we = 1'b0; run = 1'b0;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL run_timeout: %0d entries left, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1;
    check8("rst_halted", 8'(halted), 8'h01);
    check8("rst_out_valid", 8'(out_valid), 8'h00);
    check8("rst_out_data", out_data, 8'h00);
    check8("rst_pc", 8'(pc_dbg), 8'h00);
    reset = 1'b0;

    // 0x1C + 0x0E, with the final HLT word written in the same cycle as run.
    clr_img();
    img[0] = 8'h09; img[1] = 8'h1A; img[2] = 8'hE0; img[9] = 8'h1C; img[10] = 8'h0E;
    load_range(0, 2); load_range(4, 15);
    go(1, 4'h3, 8'hF0, 1);
    n = 0;
    while (!halted && n < 100) begin @(posedge clock); #1; n++; end
    check8("t1_halt_latency", 8'(n), 8'd15);
    finish_run(0, -1);
    check8("t1_out", out_data, 8'h2A);
    check8("t1_model_out", mout, 8'h2A);
    check8("t1_pc", 8'(pc_dbg), 8'h04);

    // Restart from HALT twice; a run pulse mid-program must be ignored.
    go(0, 4'h0, 8'h00, 1);
    finish_run(0, 3);
    go(0, 4'h0, 8'h00, 1);
    finish_run(0, -1);
    check8("t1b_out", out_data, 8'h2A);

    // 0xFF + 0x01 -> 0 with C=1, Z=1: JZ 7 then JC A both taken.
    clr_img();
    img[0] = 8'h0D; img[1] = 8'h1E; img[2] = 8'h87; img[3] = 8'hF0;
    img[7] = 8'h7A; img[10] = 8'hE0; img[11] = 8'hF0; img[13] = 8'hFF; img[14] = 8'h01;
    load_range(0, 15);
    go(0, 4'h0, 8'h00, 1);
    finish_run(0, -1);
    check8("t2_out", out_data, 8'h00);
    check8("t2_pc", 8'(pc_dbg), 8'h0C);

    // 0x05 - 0x07 borrows: JC not taken; RAM pokes while running are ignored.
    clr_img();
    img[0] = 8'h0D; img[1] = 8'h2E; img[2] = 8'h74; img[3] = 8'hE0; img[4] = 8'hF0;
    img[13] = 8'h05; img[14] = 8'h07;
    load_range(0, 15);
    go(0, 4'h0, 8'h00, 1);
    finish_run(8, -1);
    check8("t3_out", out_data, 8'hFE);
    check8("t3_pc", 8'(pc_dbg), 8'h05);
    img[0] = 8'h09; img[1] = 8'hE0; img[2] = 8'hF0;
    load_range(0, 2);
    go(0, 4'h0, 8'h00, 1);
    finish_run(0, -1);
    check8("t3_poke_ignored", out_data, 8'h00);

    // LDI 6; STA C; LDA C; OUT, then read mem[C] back after clearing A.
    img[0] = 8'h56; img[1] = 8'h4C; img[2] = 8'h0C; img[3] = 8'hE0; img[4] = 8'hF0;
    load_range(0, 4);
    go(0, 4'h0, 8'h00, 1);
    finish_run(0, -1);
    check8("t4_out", out_data, 8'h06);
    img[0] = 8'h50; img[1] = 8'h0C; img[2] = 8'hE0; img[3] = 8'hF0;
    load_range(0, 3);
    go(0, 4'h0, 8'h00, 1);
    finish_run(0, -1);
    check8("t4_readback", out_data, 8'h06);

    // Self-modifying program: stores HLT at 0, jumps to F (OUT), PC wraps to 0.
    clr_img();
    img[0] = 8'h65; img[5] = 8'h09; img[6] = 8'h40; img[7] = 8'h6F;
    img[9] = 8'hF0; img[15] = 8'hE0;
    load_range(0, 15);
    go(0, 4'h0, 8'h00, 1);
    finish_run(0, -1);
    check8("t5_out", out_data, 8'hF0);
    check8("t5_pc", 8'(pc_dbg), 8'h01);
    check8("t5_model_mem0", m[0], 8'hF0);

    // Reset during T4 of STA 3: no write, everything cleared.
    img[0] = 8'h55; img[1] = 8'h43; img[2] = 8'hF0; img[3] = 8'h21;
    load_range(0, 3);
    go(0, 4'h0, 8'h00, 0);
    repeat (6) @(posedge clock);
    #1;
    check8("t6_pre_pc", 8'(pc_dbg), 8'h02);
    check8("t6_pre_halted", 8'(halted), 8'h00);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    ma = 8'h00; mout = 8'h00;
    check8("t6_halted", 8'(halted), 8'h01);
    check8("t6_out_valid", 8'(out_valid), 8'h00);
    check8("t6_out_data", out_data, 8'h00);
    check8("t6_pc", 8'(pc_dbg), 8'h00);
    img[0] = 8'h03; img[1] = 8'hE0; img[2] = 8'hF0;
    load_range(0, 2);
    go(0, 4'h0, 8'h00, 1);
    finish_run(0, -1);
    check8("t6_no_write", out_data, 8'h21);

    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
